// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and byte/ShiftRows helpers.
// Byte i of a state sits at [127-8i -: 8]; row = i%4, col = i/4.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subshift_state_e;

  function automatic logic [7:0] byte_at(input logic [AES_BLOCK_W-1:0] s, input int i);
    return s[AES_BLOCK_W-1-8*i -: 8];
  endfunction

  // out byte (r,c) = in byte (r,(c+r) mod 4)
  function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[AES_BLOCK_W-1-8*(4*c+rw) -: 8] = byte_at(s, 4*((c+rw)%4) + rw);
      end
    end
    return r;
  endfunction

  function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[AES_BLOCK_W-1-8*(4*c+rw) -: 8] = byte_at(s, 4*((c-rw+4)%4) + rw);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box: combinational lookup, x = high nibble, y = low nibble.
// Zero latency; no handshake.
module sbox (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [7:0] s_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[{x_i, y_i}];

endmodule

// File: rtl/aes_subshift_iter.sv
// Iterative SubBytes+ShiftRows: 16/BYTES_PER_CYCLE cycles per block, one block in flight.
// Result held in DONE until out_ready; in_ready only while IDLE.
module aes_subshift_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_state,
  output logic                   busy
);

  localparam int N  = BYTES_PER_CYCLE;
  localparam int K  = AES_BYTES / N;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  subshift_state_e        state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] work_q, work_d;
  logic [AES_BLOCK_W-1:0] out_q, out_d;
  logic                   out_vld_q, out_vld_d;
  logic [7:0]             sb_in  [N];
  logic [7:0]             sb_out [N];
  logic                   last_chunk;

  assign last_chunk = (cnt_q == CW'(K-1));

  always_comb begin
    for (int j = 0; j < N; j++) begin
      sb_in[j] = byte_at(work_q, int'(cnt_q)*N + j);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_sbox
    sbox u_sbox (
      .x_i (sb_in[g][7:4]),
      .y_i (sb_in[g][3:0]),
      .s_o (sb_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < N; j++) begin
          work_d[AES_BLOCK_W-1-8*(int'(cnt_q)*N+j) -: 8] = sb_out[j];
        end
        // Permute straight from the just-completed state so DONE needs no extra cycle.
        if (last_chunk) begin
          cnt_d     = '0;
          out_d     = shift_rows(work_d);
          out_vld_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_vld_q;
  assign out_state = out_q;

endmodule

// File: doc/aes_subshift_iter.md
# aes_subshift_iter

Iterative SubBytes + ShiftRows stage for the AES-128 round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per cycle through parallel `sbox` instances. ShiftRows is applied when the final chunk is written. The result is presented on a valid/ready output. It sits between AddRoundKey (upstream) and MixColumns (downstream) in the round loop.

## Interface
- BYTES_PER_CYCLE, 4, number of `sbox` instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a state on in_state.
- in_ready  out  1  block can accept; equals (fsm == IDLE) & ~rst.
- in_state  in  128  input state, column-major; byte i = in_state[127-8i -: 8], with row = i%4 and col = i/4.
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  downstream accepts.
- out_state  out  128  SubBytes(ShiftRows order) result; same byte layout as in_state.
- busy  out  1  fsm != IDLE.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_state into work register, set chunk counter cnt = 0, go to RUN.
- RUN, each cycle:
  - Bytes cnt*N .. cnt*N+N-1 (N = BYTES_PER_CYCLE) of the work register pass through the N `sbox` instances and are written back in place.
  - Each `sbox` instance takes the byte high nibble as x and the low nibble as y.
  - cnt increments. cnt width is clog2(16/N), minimum 1 bit.
- Last chunk (cnt == 16/N-1):
  - out_state is loaded with the ShiftRows permutation of the fully substituted state: out byte (r,c) = sub byte (r,(c+r) mod 4).
  - Go to DONE.
- DONE: out_valid = 1; out_state is held stable. On out_ready, go to IDLE.
- No overlap between blocks: in_ready is 0 in RUN and DONE, and in_valid is ignored there.
- in_state changes while not handshaking have no effect.
- out_ready outside DONE is ignored.
- Reset (asynchronous, any state, including mid-RUN): fsm = IDLE, cnt = 0, work register = 0, out_state = 0, out_valid = 0, busy = 0. The in-flight block is discarded with no partial output.
- Output values while rst is high: in_ready = 0, out_valid = 0, busy = 0, out_state = 128'h0.

## Timing
- Let K = 16/N.
- Input accepted at edge E. Chunks are written at edges E+1 … E+K. out_valid rises after edge E+K.
  - Latency is K cycles (default: 4 cycles).
- Output accepted at edge F: out_valid falls and in_ready rises after F. The next input can be accepted at edge F+1 at the earliest.
- Peak throughput is one block per K+2 cycles (6 at default).
- out_valid and out_state are registered.
- in_ready and busy are decoded from the FSM register. There is no combinational path from in_valid or out_ready to any output.
- out_ready held low: the block stays in DONE indefinitely, with out_state and out_valid unchanged.

## Structure
- Shared package `aes_pkg`:
  - AES_BLOCK_W = 128.
  - AES_BYTES = 16.
  - Function shift_rows(128) → 128, reused by the decrypt path with an inverse variant.
  - Byte-slice helper byte_at(state, i).
- Sub-module: `sbox`, existing, instantiated BYTES_PER_CYCLE times via generate. This block adds no new sub-module.

## Test plan
- FIPS-197 App. B round 1: in_state = 193de3be_a0f4e22b_9ac68d2a_e9f84808 → out_state = d4bf5d30_e0b452ae_b84111f1_1e2798e5. out_valid is seen exactly 4 cycles after acceptance.
- Uniform inputs: all-0x00 → 63636363_63636363_63636363_63636363; all-0x52 → 128'h0. ShiftRows is invisible here, so this isolates the S-box path.
- Backpressure: out_ready held low 10 cycles after out_valid.
  - out_state is stable, in_ready = 0, and a second in_valid pulse is ignored.
  - On release, the next block is accepted one cycle after the output handshake.
- Reset mid-RUN: assert rst asynchronously 2 cycles after acceptance.
  - All outputs go to their reset values immediately; no out_valid follows.
  - A fresh block afterward gives the correct result.
- Parameter sweep BYTES_PER_CYCLE = 1, 2, 8, 16 with the App. B vector:
  - Same out_state each time.
  - Latency 16, 8, 2, 1 cycles respectively.
- Back-to-back random stream with random out_ready: 1000 blocks compared against a reference-model SubBytes+ShiftRows. There must be no drops or duplicates.
